// File: rtl/key_switch_conditioner.sv
// Synchronizes and debounces two active-low push-buttons and four slide switches.
// Produces clean levels, one-cycle edge pulses and an Avalon-MM read-only status port.
module key_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  key_n,
    input  logic [3:0]  switch_raw,
    output logic [1:0]  key,
    output logic [1:0]  key_press,
    output logic [1:0]  key_release,
    output logic [3:0]  switch,
    output logic [3:0]  switch_change,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata
);

    localparam int               N         = 6;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Keys idle high (released), switches idle low; also the inversion mask for keys.
    localparam logic [N-1:0]     SYNC_IDLE = 6'b00_0011;

    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     s;
    logic [N-1:0]     stable;
    logic [N-1:0]     rise;
    logic [N-1:0]     fall;
    logic [CNT_W-1:0] cnt [N];
    logic [1:0]       press_sticky;
    logic [3:0]       chg_sticky;
    logic [31:0]      rd_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= {switch_raw, key_n};
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ SYNC_IDLE;

    // NOTE: the counter array is ordinary flops, not RAM, so it is reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            rise   <= '0;
            fall   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < N; i++) begin
                if (s[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    stable[i] <= s[i];
                    rise[i]   <= s[i];
                    fall[i]   <= ~s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign key           = stable[1:0];
    assign switch        = stable[5:2];
    assign key_press     = rise[1:0];
    assign key_release   = fall[1:0];
    assign switch_change = rise[5:2] | fall[5:2];

    // NOTE: rd_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next = {26'b0, chg_sticky, press_sticky};
            2'd1:    rd_next = {26'b0, stable};
            default: ;
        endcase
    end

    // A pulse coinciding with a clearing read survives into the sticky register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_sticky <= '0;
            chg_sticky   <= '0;
            readdata     <= '0;
        end else begin
            if (read) begin
                readdata <= rd_next;
            end
            if (read && address == 2'd0) begin
                press_sticky <= key_press;
                chg_sticky   <= switch_change;
            end else begin
                press_sticky <= press_sticky | key_press;
                chg_sticky   <= chg_sticky | switch_change;
            end
        end
    end

endmodule
